// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair.
// State encoding widens to 3 bits when UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;
`endif

    function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                   input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CYCLES_PER_BIT-1 while enabled and flags the
// final cycle of each bit. Shared with the UART receiver.
module uart_baud_cnt #(
    parameter int unsigned CYCLES_PER_BIT = 434
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Last
);

    localparam int unsigned CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] r_Cnt;
    logic             w_AtLast;

    assign w_AtLast = (r_Cnt == LAST_CNT);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Cnt <= '0;
        end else if (i_Clr) begin
            r_Cnt <= '0;
        end else if (i_En) begin
            r_Cnt <= w_AtLast ? '0 : r_Cnt + 1'b1;
        end
    end

    assign o_Last = i_En && w_AtLast;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first, with a one-byte holding register for
// gap-free back-to-back frames. Define UART_TX_PARITY_EN to add a parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD)
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit          PARITY_ODD     = 1'b0
`endif
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_fStart,
    input  logic [DATA_BITS-1:0] i_Data,
    output logic                 o_fReady,
    output logic                 o_fBusy,
    output logic                 o_fDone,
    output logic                 o_Tx
);

    tx_state_t              r_State;
    logic [DATA_BITS-1:0]   r_Hold;
    logic [DATA_BITS-1:0]   r_Shift;
    logic [BIT_IDX_W-1:0]   r_BitCnt;
    logic                   r_Ready;
    logic                   r_Busy;
    logic                   r_Done;
    logic                   r_Tx;

    logic                   w_Active;
    logic                   w_BitLast;
    logic                   w_Accept;
    logic                   w_Load;

    assign w_Active = (r_State != ST_IDLE);
    assign w_Accept = i_fStart && r_Ready;
    assign w_Load   = !r_Ready &&
                      ((r_State == ST_IDLE) || ((r_State == ST_STOP) && w_BitLast));

    uart_baud_cnt #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_baud_cnt (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Clr (!w_Active),
        .i_En  (w_Active),
        .o_Last(w_BitLast)
    );

    // Holding register; occupancy is the only thing o_fReady reports.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Hold  <= '0;
            r_Ready <= 1'b1;
        end else if (w_Accept) begin
            r_Hold  <= i_Data;
            r_Ready <= 1'b0;
        end else if (w_Load) begin
            r_Ready <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_Parity;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Parity <= 1'b0;
        end else if (w_Load) begin
            r_Parity <= (^r_Hold) ^ PARITY_ODD;
        end
    end
`endif

    // o_Tx is driven from the state held during the previous cycle, so every
    // line level trails its state by one clock but still lasts a full bit.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State  <= ST_IDLE;
            r_Shift  <= '0;
            r_BitCnt <= '0;
            r_Busy   <= 1'b0;
            r_Done   <= 1'b0;
            r_Tx     <= 1'b1;
        end else begin
            r_Done <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    r_Tx <= 1'b1;
                    if (w_Load) begin
                        r_Shift <= r_Hold;
                        r_State <= ST_START;
                        r_Busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    r_Tx <= 1'b0;
                    if (w_BitLast) begin
                        r_State <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_Tx <= r_Shift[0];
                    if (w_BitLast) begin
                        r_Shift <= r_Shift >> 1;
                        if (r_BitCnt == BIT_IDX_W'(DATA_BITS - 1)) begin
                            r_BitCnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_State  <= ST_PARITY;
`else
                            r_State  <= ST_STOP;
`endif
                        end else begin
                            r_BitCnt <= r_BitCnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    r_Tx <= r_Parity;
                    if (w_BitLast) begin
                        r_State <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    r_Tx <= 1'b1;
                    if (w_BitLast) begin
                        r_Done <= 1'b1;
                        if (w_Load) begin
                            r_Shift <= r_Hold;
                            r_State <= ST_START;
                        end else begin
                            r_State <= ST_IDLE;
                            r_Busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_Tx    <= 1'b1;
                    r_State <= ST_IDLE;
                    r_Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_fReady = r_Ready;
    assign o_fBusy  = r_Busy;
    assign o_fDone  = r_Done;
    assign o_Tx     = r_Tx;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue of expected per-cycle line levels
// built from the frame format is compared against the DUT every clock.
module tb_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
    localparam bit          PAR_ODD    = 1'b0;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       f_start = 1'b0;
    logic [7:0] data    = '0;
    logic       tx, ready, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;

    bit          q_lvl[$];
    bit          q_done[$];
    bit          m_full = 1'b0;
    logic [7:0]  m_hold = '0;
    bit          e_tx   = 1'b1;
    bit          e_done = 1'b0;

    int unsigned done_cnt  = 0;
    int unsigned done_last = 0;
    int unsigned done_prev = 0;

    uart_tx #(
        .CYCLES_PER_BIT(CPB)
    ) dut (
        .i_Clk   (clk),
        .i_Rst   (rst_n),
        .i_fStart(f_start),
        .i_Data  (data),
        .o_fReady(ready),
        .o_fBusy (busy),
        .o_fDone (done),
        .o_Tx    (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(bit'(($countones(b) % 2) == 1) ^ PAR_ODD);
`endif
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < int'(CPB); c++) begin
                q_lvl.push_back(bits[k]);
                q_done.push_back((k == bits.size() - 1) && (c == int'(CPB) - 1));
            end
        end
    endtask

    task automatic model_reset();
        q_lvl.delete();
        q_done.delete();
        m_full = 1'b0;
        e_tx   = 1'b1;
        e_done = 1'b0;
    endtask

    task automatic check_outputs();
        check("tx", tx, e_tx);
        check("ready", ready, !m_full);
        check("busy", busy, q_lvl.size() > 0);
        check("done", done, e_done);
    endtask

    task automatic cycle();
        bit ready_pre;
        @(posedge clk);
        cyc++;
        ready_pre = !m_full;
        if (q_lvl.size() > 0) begin
            e_tx   = q_lvl.pop_front();
            e_done = q_done.pop_front();
        end else begin
            e_tx   = 1'b1;
            e_done = 1'b0;
        end
        if (m_full && q_lvl.size() == 0) begin
            push_frame(m_hold);
            m_full = 1'b0;
        end
        if (f_start && ready_pre) begin
            m_hold = data;
            m_full = 1'b1;
        end
        #1;
        check_outputs();
        if (done === 1'b1) begin
            done_cnt++;
            done_prev = done_last;
            done_last = cyc;
        end
    endtask

    task automatic send(input logic [7:0] b);
        f_start = 1'b1;
        data    = b;
        cycle();
        f_start = 1'b0;
        data    = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * int'(FRAME_CYC) && (q_lvl.size() > 0 || m_full); i++) cycle();
        check_int("drain_empty", q_lvl.size() + int'(m_full), 0);
        repeat (3) cycle();
    endtask

    initial begin
        int unsigned acc;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (3) cycle();
        rst_n = 1'b1;

        // Idle with random data noise and no start
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            data = 8'($urandom);
            cycle();
        end
        check_int("idle_no_done", int'(done_cnt), 0);

        // Single frame 0xA5
        done_cnt = 0;
        send(8'hA5);
        acc = cyc;
        drain();
        check_int("a5_done_count", int'(done_cnt), 1);
        check_int("a5_done_cycle", int'(done_last), int'(acc + 1 + FRAME_CYC));

        // Queued frame during DATA, plus ignored start while full
        done_cnt = 0;
        send(8'h3C);
        repeat (12) cycle();
        send(8'hFF);
        check("ready_low_after_queue", ready, 1'b0);
        f_start = 1'b1;
        data    = 8'h11;
        repeat (5) cycle();
        f_start = 1'b0;
        drain();
        check_int("b2b_done_count", int'(done_cnt), 2);
        check_int("b2b_done_spacing", int'(done_last - done_prev), int'(FRAME_CYC));

        // Reset in the middle of data bit 4
        send(8'($urandom));
        repeat (22) cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", ready, 1'b1);
        check("rst_mid_done", done, 1'b0);
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        done_cnt = 0;
        send(8'h00);
        drain();
        check_int("zero_done_count", int'(done_cnt), 1);

        // Parity reference byte (plain 8N1 frame in the default build)
        send(8'h07);
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            f_start = ($urandom_range(0, 3) == 0);
            data    = 8'($urandom);
            cycle();
        end
        f_start = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
